// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Also used by any unrolled/pipelined converter built on bcd_dabble_step.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  localparam int BCD_DIGIT_W = 4;

  // Decimal digits of 2**bin_w-1: ceil(bin_w*log10(2)), never a power of ten
  function automatic int bcd_digits_needed(input int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_convert_ctrl_if.sv
// Valid/ready bundle between a binary source, the converter and a BCD sink.
// master drives operands and out_ready; slave is the converter side.
interface bcd_convert_ctrl_if
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);

  localparam int W = BCD_DIGIT_W * DIGITS;

  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_bcd;
  logic             busy;

  modport master (
    output in_valid,
    output in_bin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bcd,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_bin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bcd,
    output busy
  );

endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit above 4, then
// shift left one bit taking bit_in as the new LSB.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  input  logic                          bit_in,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int W = BCD_DIGIT_W * DIGITS;

  logic [W-1:0] adj;

  // Per-digit add, no carry between digits
  always_comb begin
    adj = bcd_in;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_in[k*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd4) begin
        adj[k*BCD_DIGIT_W +: BCD_DIGIT_W] =
          bcd_in[k*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
    end
  end

  assign bcd_out = (adj << 1) | W'(bit_in);

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter: one dabble step per clock,
// valid/ready on both sides, result held until the sink takes it.
module bcd_convert_ctrl
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input logic                clk,
  input logic                rst,
  bcd_convert_ctrl_if.slave  bus
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  if (BIN_W < 1 || bcd_digits_needed(BIN_W) > DIGITS) begin : g_bad_cfg
    $error("bcd_convert_ctrl: DIGITS too small for BIN_W");
  end

  bcd_state_t       state_q, state_d;
  logic [BIN_W-1:0] bin_sr_q, bin_sr_d;
  logic [W-1:0]     bcd_acc_q, bcd_acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     out_bcd_q, out_bcd_d;
  logic [W-1:0]     step_out;
  logic             accept;

  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .bcd_in  (bcd_acc_q),
    .bit_in  (bin_sr_q[BIN_W-1]),
    .bcd_out (step_out)
  );

  assign bus.in_ready  = !rst && ((state_q == IDLE) ||
                         ((state_q == DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.out_bcd   = out_bcd_q;

  always_comb begin
    state_d   = state_q;
    bin_sr_d  = bin_sr_q;
    bcd_acc_d = bcd_acc_q;
    cnt_d     = cnt_q;
    out_bcd_d = out_bcd_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bin_sr_d  = bus.in_bin;
          bcd_acc_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bcd_acc_d = step_out;
        bin_sr_d  = bin_sr_q << 1;
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          out_bcd_d = step_out;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
        // Back-to-back: next operand loads in the same cycle as the transfer
        if (accept) begin
          bin_sr_d  = bus.in_bin;
          bcd_acc_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_sr_q  <= '0;
      bcd_acc_q <= '0;
      cnt_q     <= '0;
      out_bcd_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_sr_q  <= bin_sr_d;
      bcd_acc_q <= bcd_acc_d;
      cnt_q     <= cnt_d;
      out_bcd_q <= out_bcd_d;
    end
  end

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Randomised and directed bench for bcd_convert_ctrl against a
// transaction-level model (decimal arithmetic, countdown, result queue).
module tb_bcd_convert_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_convert_ctrl_if #(.BIN_W(8),  .DIGITS(3)) bus8  ();
  bcd_convert_ctrl_if #(.BIN_W(16), .DIGITS(5)) bus16 ();

  bcd_convert_ctrl #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  bcd_convert_ctrl #(.BIN_W(16), .DIGITS(5)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit started = 0;

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model for the 8-bit instance
  bit          m_busy;
  bit          m_have;
  bit          m_rdy;
  int          m_left;
  logic [7:0]  m_op;
  logic [31:0] m_bcd;
  logic [7:0]  sbq[$];

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_have = 0;
      m_left = 0;
      m_bcd  = '0;
      sbq.delete();
    end else begin
      m_rdy = (!m_busy && !m_have) || (m_have && bus8.out_ready);
      if (m_have && bus8.out_ready) m_have = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_have = 1;
          m_bcd  = to_bcd(m_op);
        end
      end
      if (bus8.in_valid && m_rdy) begin
        m_busy = 1;
        m_left = 8;
        m_op   = bus8.in_bin;
        sbq.push_back(bus8.in_bin);
      end
    end
  end

  // Every-cycle compare plus in-order result scoreboard
  logic [7:0] sb_op;
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(bus8.out_valid), 32'(m_have));
      chk("busy", 32'(bus8.busy), 32'(m_busy));
      chk("in_ready", 32'(bus8.in_ready),
          32'(!rst && ((!m_busy && !m_have) || (m_have && bus8.out_ready))));
      chk("out_bcd", 32'(bus8.out_bcd), m_bcd);
      if (!rst && bus8.out_valid && bus8.out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 32'(sbq.size()), 32'd1);
        end else begin
          sb_op = sbq.pop_front();
          chk("sb_order", 32'(bus8.out_bcd), to_bcd(sb_op));
        end
      end
    end
  end

  task automatic wait_valid8(output int k);
    k = 0;
    while (!bus8.out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int k;
  int v;
  int cyc;
  int first_acc;
  int last_acc;
  int vcount;
  bit acc;

  initial begin
    bus8.in_valid   = 0;
    bus8.in_bin     = '0;
    bus8.out_ready  = 0;
    bus16.in_valid  = 0;
    bus16.in_bin    = '0;
    bus16.out_ready = 1;

    // Model pins
    chk("model_255", to_bcd(255), 32'h255);
    chk("model_99",  to_bcd(99),  32'h099);
    chk("model_200", to_bcd(200), 32'h200);
    chk("model_65535", to_bcd(65535), 32'h65535);

    @(posedge clk);
    started = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_out_bcd", 32'(bus8.out_bcd), 32'd0);
    chk("rst16_out_bcd", 32'(bus16.out_bcd), 32'd0);
    rst = 0;

    // 255 with sink ready: latency and value
    @(posedge clk); #1;
    bus8.out_ready = 1;
    bus8.in_valid  = 1;
    bus8.in_bin    = 8'd255;
    @(posedge clk); #1;
    bus8.in_valid = 0;
    wait_valid8(k);
    chk("lat_255", 32'(k), 32'd8);
    chk("bcd_255", 32'(bus8.out_bcd), 32'h255);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back sweep 0..255
    bus8.in_valid = 1;
    v = 0;
    bus8.in_bin = 8'(v);
    cyc = 0;
    first_acc = -1;
    last_acc = -1;
    while (v < 256 && cyc < 256 * 9 + 50) begin
      acc = bus8.in_ready;
      @(posedge clk);
      cyc++;
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        v++;
      end
      #1;
      bus8.in_bin = 8'(v);
    end
    bus8.in_valid = 0;
    chk("sweep_count", 32'(v), 32'd256);
    chk("sweep_period", 32'(last_acc - first_acc), 32'(255 * 9));
    repeat (12) @(posedge clk);
    #1;

    // Backpressure with a competing operand held on the input
    bus8.out_ready = 0;
    bus8.in_valid  = 1;
    bus8.in_bin    = 8'd128;
    @(posedge clk); #1;
    bus8.in_bin = 8'd5;
    wait_valid8(k);
    chk("lat_128", 32'(k), 32'd8);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_valid", 32'(bus8.out_valid), 32'd1);
    chk("bp_bcd", 32'(bus8.out_bcd), 32'h128);
    chk("bp_in_ready", 32'(bus8.in_ready), 32'd0);
    bus8.in_valid  = 0;
    bus8.out_ready = 1;
    @(posedge clk); #1;
    bus8.out_ready = 0;
    chk("bp_after_valid", 32'(bus8.out_valid), 32'd0);
    chk("bp_after_idle", 32'(bus8.in_ready), 32'd1);
    chk("bp_after_busy", 32'(bus8.busy), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus8.in_valid  = ($urandom_range(0, 2) != 0);
      bus8.in_bin    = 8'($urandom);
      bus8.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus8.in_valid  = 0;
    bus8.out_ready = 1;
    repeat (12) @(posedge clk);
    #1;

    // Reset during the 4th SHIFT cycle of 77
    bus8.in_valid = 1;
    bus8.in_bin   = 8'd77;
    @(posedge clk); #1;
    bus8.in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_valid", 32'(bus8.out_valid), 32'd0);
    chk("abort_bcd", 32'(bus8.out_bcd), 32'd0);
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus8.out_valid) vcount++;
    end
    chk("abort_no_valid", 32'(vcount), 32'd0);
    bus8.in_valid = 1;
    bus8.in_bin   = 8'd42;
    @(posedge clk); #1;
    bus8.in_valid = 0;
    wait_valid8(k);
    chk("lat_42", 32'(k), 32'd8);
    chk("bcd_42", 32'(bus8.out_bcd), 32'h042);
    repeat (3) @(posedge clk);
    #1;

    // 16-bit instance
    bus16.in_valid = 1;
    bus16.in_bin   = 16'hFFFF;
    @(posedge clk); #1;
    bus16.in_valid = 0;
    k = 0;
    while (!bus16.out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("lat_ffff", 32'(k), 32'd16);
    chk("bcd_ffff", 32'(bus16.out_bcd), 32'h65535);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
